// File: rtl/cpu_mem_pkg.sv
// Shared constants and types for the CPU-side memory responder slice.
package cpu_mem_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } stateT;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } opT;

endpackage

// File: rtl/memory_responder_if.sv
// CPU request/response bus plus the boot-loader preload port.
interface memory_responder_if;
    import cpu_mem_pkg::*;

    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] memoryIn;
    logic [DATA_W-1:0] memoryOut;
    logic              ready;
    logic              busy;
    logic              err;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;

    modport master (
        output read, write, address, memoryIn, prog_we, prog_addr, prog_data,
        input  memoryOut, ready, busy, err
    );

    modport slave (
        input  read, write, address, memoryIn, prog_we, prog_addr, prog_data,
        output memoryOut, ready, busy, err
    );

endinterface

// File: rtl/mem_array.sv
// 16x8 register file: async clear, one shared write port, combinational read.
module mem_array
    import cpu_mem_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              cpuWe,
    input  logic [ADDR_W-1:0] cpuAddr,
    input  logic [DATA_W-1:0] cpuData,
    input  logic              progWe,
    input  logic [ADDR_W-1:0] progAddr,
    input  logic [DATA_W-1:0] progData,
    input  logic [ADDR_W-1:0] readAddr,
    output logic [DATA_W-1:0] readData
);

    logic [DATA_W-1:0] words [DEPTH];
    logic              writeEn;
    logic [ADDR_W-1:0] writeAddr;
    logic [DATA_W-1:0] writeData;

    // The two writers are mutually exclusive by FSM state, so CPU simply wins the mux
    always_comb begin
        writeEn   = cpuWe | progWe;
        writeAddr = progAddr;
        writeData = progData;
        if (cpuWe) begin
            writeAddr = cpuAddr;
            writeData = cpuData;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                words[i] <= '0;
            end
        end else if (writeEn) begin
            words[writeAddr] <= writeData;
        end
    end

    assign readData = words[readAddr];

endmodule

// File: rtl/memory_responder.sv
// Single-outstanding CPU memory responder with programmable wait states and preload port.
module memory_responder
    import cpu_mem_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0
) (
    input logic               clk,
    input logic               clr,
    memory_responder_if.slave bus
);

    localparam logic [1:0] WAIT_LOAD = 2'(WAIT_STATES);

    stateT             state;
    stateT             nextState;
    logic [1:0]        waitCount;
    opT                latchedOp;
    logic [ADDR_W-1:0] latchedAddr;
    logic [DATA_W-1:0] latchedData;
    logic [DATA_W-1:0] memoryOutReg;
    logic [DATA_W-1:0] readData;
    logic              errReg;
    logic              request;
    logic              conflict;
    logic              doAccess;
    logic              cpuWe;
    logic              progWe;

    assign request  = bus.read ^ bus.write;
    assign conflict = bus.read & bus.write;
    assign doAccess = (state == BUSY) && (waitCount == 2'd0);
    assign cpuWe    = doAccess && (latchedOp == OP_WRITE);
    assign progWe   = bus.prog_we && (state == IDLE);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (request) nextState = BUSY;
            BUSY:    if (waitCount == 2'd0) nextState = RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Request capture, wait countdown, registered read data and the err pulse
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            waitCount    <= 2'd0;
            latchedOp    <= OP_READ;
            latchedAddr  <= '0;
            latchedData  <= '0;
            memoryOutReg <= '0;
            errReg       <= 1'b0;
        end else begin
            errReg <= (state == IDLE) && conflict;
            if ((state == IDLE) && request) begin
                latchedOp   <= bus.write ? OP_WRITE : OP_READ;
                latchedAddr <= bus.address;
                latchedData <= bus.memoryIn;
                waitCount   <= WAIT_LOAD;
            end else if ((state == BUSY) && (waitCount != 2'd0)) begin
                waitCount <= waitCount - 2'd1;
            end
            if (doAccess && (latchedOp == OP_READ)) begin
                memoryOutReg <= readData;
            end
        end
    end

    mem_array u_memArray (
        .clk      (clk),
        .clr      (clr),
        .cpuWe    (cpuWe),
        .cpuAddr  (latchedAddr),
        .cpuData  (latchedData),
        .progWe   (progWe),
        .progAddr (bus.prog_addr),
        .progData (bus.prog_data),
        .readAddr (latchedAddr),
        .readData (readData)
    );

    assign bus.memoryOut = memoryOutReg;
    assign bus.ready     = (state == RESP);
    assign bus.busy      = (state != IDLE);
    assign bus.err       = errReg;

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 The block SHALL have parameter WAIT_STATES, default 0, legal 0..3: extra cycles inserted before each access.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 clr  input  1  reset, asynchronous and active-low.
REQ-004 read  input  1  CPU read request, level, sampled only in IDLE.
REQ-005 write  input  1  CPU write request, level, sampled only in IDLE.
REQ-006 address  input  4  CPU word address, 16 locations, no wrap logic needed.
REQ-007 memoryIn  input  8  write data from CPU bus.
REQ-008 memoryOut  output  8  registered read data to CPU.
REQ-009 ready  output  1  one-cycle pulse: access complete.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 err  output  1  one-cycle pulse: illegal request (read and write together).
REQ-012 prog_we  input  1  preload write strobe from the test/boot loader.
REQ-013 prog_addr  input  4  preload address.
REQ-014 prog_data  input  8  preload data.

Function
REQ-015 The FSM SHALL have states IDLE, BUSY and RESP.
REQ-016 In IDLE, at an edge with exactly one of read/write high: the FSM SHALL latch op, address and memoryIn, load the wait counter with WAIT_STATES, and go to BUSY.
REQ-017 In IDLE, at an edge with read and write both high: no access SHALL occur, err SHALL pulse high the next cycle, and the FSM SHALL stay in IDLE.
REQ-018 In BUSY with counter > 0: each edge SHALL decrement the counter.
REQ-019 In BUSY with counter = 0, at the edge: the access SHALL be performed and the FSM SHALL go to RESP.
REQ-020 The access SHALL be: write -> array[latched address] <= latched data, memoryOut unchanged; read -> memoryOut <= array[latched address].
REQ-021 In RESP, ready SHALL be 1 for exactly one cycle, and the next edge SHALL return the FSM to IDLE.
REQ-022 Latency from request-sampling edge N to ready high SHALL be the cycle after edge N+1+WAIT_STATES.
REQ-023 read/write/address/memoryIn SHALL be ignored in BUSY and RESP.
REQ-024 A request still held high at the first IDLE edge after RESP SHALL be accepted as a new request.
REQ-025 memoryOut SHALL hold its last read value until the next read access completes.
REQ-026 prog_we SHALL write prog_data to array[prog_addr] at the edge, only when state is IDLE; outside IDLE it SHALL be ignored.
REQ-027 prog_we and a CPU request at the same IDLE edge SHALL both take effect: the preload is written immediately and the CPU request is accepted.
REQ-028 A later CPU read of that address SHALL return the preloaded value.
REQ-029 ready and err SHALL never both be high in the same cycle.

Reset
REQ-030 clr low SHALL immediately set state IDLE, counter 0, memoryOut 0x00, ready 0, busy 0, err 0, and all 16 array words 0x00.
REQ-031 A reset during BUSY or RESP SHALL abort the access, with no write performed and no ready pulse.
REQ-032 The first edge after clr rises SHALL be able to sample a request.

Structure
REQ-033 Shared package cpu_mem_pkg SHALL hold DATA_W=8, ADDR_W=4, DEPTH=16 and the state enum (IDLE, BUSY, RESP).
REQ-034 Sub-module mem_array SHALL implement the storage: 16x8 registers with async clear, one write port muxed between the CPU path and the preload path, and one combinational read port.

Verification
REQ-035 Preload 0xA5 at address 3, then read 3 (WAIT_STATES=0) -> ready in the cycle after edge N+1, memoryOut=0xA5, busy high for 2 cycles.
REQ-036 Write 0x3C to address 15, then read 15 (WAIT_STATES=2) -> each ready arrives 3 edges after its request, memoryOut=0x3C.
REQ-037 read=1 and write=1 at address 7 holding 0x11 -> err pulses once, no ready, array[7] stays 0x11, state stays IDLE.
REQ-038 Hold read=1 continuously at address 0 -> back-to-back ready pulses every 3 cycles (WAIT_STATES=0); prog_we during BUSY is ignored.
REQ-039 Write 0xFF to address 5 with clr pulsed low during BUSY -> ready never pulses, array[5]=0x00, memoryOut=0x00.
REQ-040 prog_we for address 9 (0x42) in the same IDLE edge as a read of address 9 -> memoryOut=0x42 at ready.
